iiitb_usr_cmd_ctrl: RTL and testbench
=====================================

// Module: iiitb_usr_cmd_ctrl
// PURPOSE
//  Command sequencer sitting directly upstream of the 8-bit universal shift register (iiitb_usr).
//  Accepts one command at a time over a valid/ready handshake (load, shift-left N, shift-right N, read).
//  Drives the USR select/data_in/serial inputs cycle by cycle, then captures the USR data_out.
//  Returns the captured word over a valid/ready response channel.
// PARAMETERS
//  WIDTH  8  data width; matches the USR word width
//  CNT_W  4  width of shift-count field; max shifts per command = 2**CNT_W-1
// PORTS
//  clock         in   1      single clock; all state updates on posedge
//  clear         in   1      asynchronous, active-high reset; shared with the USR
//  cmd_valid     in   1      command present
//  cmd_ready     out  1      controller can accept a command (IDLE only)
//  cmd_op        in   2      00 shift-left, 01 shift-right, 10 load, 11 read
//  cmd_count     in   CNT_W  number of shift cycles (shift ops only)
//  cmd_data      in   WIDTH  parallel load value (load op only)
//  cmd_ser       in   1      serial fill bit for shifts
//  usr_select    out  2      to USR select: 00 left, 01 right, 10 load, 11 hold
//  usr_data_in   out  WIDTH  to USR data_in
//  usr_sl_ser    out  1      to USR sl_ser
//  usr_sr_ser    out  1      to USR sr_ser
//  usr_data_out  in   WIDTH  from USR data_out
//  rsp_valid     out  1      response word available
//  rsp_ready     in   1      consumer takes the response
//  rsp_data      out  WIDTH  captured USR contents
//  busy          out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset (clear=1, async): state=IDLE; cmd_ready=0; rsp_valid=0; rsp_data=0; busy=0.
//   Also during reset: usr_select=11, usr_data_in=0, usr_sl_ser=usr_sr_ser=0.
//   cmd_ready rises at the first posedge after clear falls.
//  All outputs are registered. Command latch regs (op, count, data, ser) load only on accept.
//  Accept = cmd_valid & cmd_ready at posedge. cmd_ready=1 only in IDLE and not in reset.
//  FSM states: IDLE, LOAD, SHIFT, CAPTURE, RESP.
//   IDLE: usr_select=11.
//     accept op 10 -> LOAD.
//     accept op 00/01 with count>0 -> SHIFT.
//     accept op 00/01 with count=0 -> CAPTURE.
//     accept op 11 -> CAPTURE.
//   LOAD: one cycle; usr_select=10, usr_data_in=latched data -> CAPTURE.
//   SHIFT: usr_select=latched op; usr_sl_ser=usr_sr_ser=latched ser.
//     Down-counter is preset to count; decrements each cycle.
//     Exactly count shift cycles, then -> CAPTURE.
//   CAPTURE: usr_select=11 (hold); rsp_data<=usr_data_out at end of cycle -> RESP.
//   RESP: rsp_valid=1; rsp_data stable; usr_select=11.
//     rsp_valid&rsp_ready at posedge -> IDLE, rsp_valid=0.
//  usr_data_in, usr_sl_ser and usr_sr_ser return to 0 outside LOAD/SHIFT.
//  Latency, counted in posedges after the accept edge e0:
//   shift N>0: rsp_valid high from e(N+2).
//   load: rsp_valid high from e3.
//   read, or shift N=0: rsp_valid high from e2.
//  Next accept no earlier than the posedge following the response handshake; no overlap.
//  cmd_* inputs are ignored while not in IDLE; they may change freely.
//  Count = 2**CNT_W-1: full-length shift with no wrap; counter never underflows.
//  rsp_ready held low: stay in RESP indefinitely, rsp_data unchanged.
//  rsp_ready high in other states: no effect.
//  clear mid-operation: immediate return to reset values; the in-flight command is dropped
//   with no response. The USR is cleared by the same signal.
// TESTING (USR model: right={sr_ser,q[7:1]}, left={q[6:0],sl_ser})
//  T1 reset: clear=1 for 2 cycles -> cmd_ready=0, rsp_valid=0, usr_select=11; after release, cmd_ready=1 at next edge.
//  T2 load: op=10, data=8'hAB -> usr_select=10 for 1 cycle; rsp_valid from e3; rsp_data=8'hAB.
//  T3 right shift after T2: op=01, count=3, ser=1 -> 3 cycles of select=01; rsp_data=8'hF5; rsp_valid at e5.
//  T4 left shift from 8'hAB: op=00, count=2, ser=0 -> rsp_data=8'hAC.
//  T5 read/zero-count from 8'hAB: op=11 and op=01 count=0 -> no USR activity, rsp_data=8'hAB at e2.
//     Hold rsp_ready=0 for 4 cycles -> rsp_valid/rsp_data stable and cmd_ready=0.
//  T6 reset mid-shift: op=01, count=5, clear pulsed after 2 shifts -> outputs at reset values immediately, no rsp_valid.
//     Then load 8'h3C -> rsp_data=8'h3C.

Source files
------------

// File: rtl/iiitb_usr_cmd_ctrl.sv
// iiitb_usr_cmd_ctrl: command sequencer driving the 8-bit universal shift register and returning its contents
module iiitb_usr_cmd_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_ser,
    output logic [1:0]       usr_select,
    output logic [WIDTH-1:0] usr_data_in,
    output logic             usr_sl_ser,
    output logic             usr_sr_ser,
    input  logic [WIDTH-1:0] usr_data_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPTURE, RESP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               ser_q, ser_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [1:0]         sel_q, sel_d;
    logic [WIDTH-1:0]   din_q, din_d;
    logic               sser_q, sser_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               busy_q, busy_d;

    // Next state plus outputs decoded from the next state, so every output is a flop aligned with its state
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        ser_d      = ser_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready_q) begin
                op_d    = cmd_op;
                cnt_d   = cmd_count;
                data_d  = cmd_data;
                ser_d   = cmd_ser;
                state_d = (cmd_op == 2'b10) ? LOAD :
                          (!cmd_op[1] && cmd_count != '0) ? SHIFT : CAPTURE;
            end
            LOAD:    state_d = CAPTURE;
            SHIFT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CNT_W'(1)) ? CAPTURE : SHIFT;
            end
            CAPTURE: begin
                rsp_data_d = usr_data_out;
                state_d    = RESP;
            end
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        sel_d       = (state_d == LOAD) ? 2'b10 : (state_d == SHIFT) ? {1'b0, op_d[0]} : 2'b11;
        din_d       = (state_d == LOAD) ? data_d : '0;
        sser_d      = (state_d == SHIFT) && ser_d;
        rsp_valid_d = (state_d == RESP);
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State, command latch and registered outputs; clear drops any in-flight command
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            ser_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            sel_q       <= 2'b11;
            din_q       <= '0;
            sser_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            ser_q       <= ser_d;
            cmd_ready_q <= cmd_ready_d;
            sel_q       <= sel_d;
            din_q       <= din_d;
            sser_q      <= sser_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign usr_select  = sel_q;
    assign usr_data_in = din_q;
    assign usr_sl_ser  = sser_q;
    assign usr_sr_ser  = sser_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_iiitb_usr_cmd_ctrl.sv
// tb_iiitb_usr_cmd_ctrl: directed and randomized checks of the USR command sequencer against a word-level model
module tb_iiitb_usr_cmd_ctrl;
    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_count = 4'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ser = 1'b0;
    logic [1:0] usr_select;
    logic [7:0] usr_data_in;
    logic       usr_sl_ser;
    logic       usr_sr_ser;
    logic [7:0] usr_data_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       busy;

    int         n_chk = 0;
    int         n_fail = 0;
    int         ref_v = 0;
    logic [7:0] last_rsp;
    logic [7:0] usr_q;

    iiitb_usr_cmd_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .cmd_ser(cmd_ser),
        .usr_select(usr_select), .usr_data_in(usr_data_in), .usr_sl_ser(usr_sl_ser),
        .usr_sr_ser(usr_sr_ser), .usr_data_out(usr_data_out), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural universal shift register sitting downstream of the controller
    always @(posedge clock or posedge clear) begin
        if (clear) usr_q <= 8'd0;
        else case (usr_select)
            2'b00: usr_q <= {usr_q[6:0], usr_sl_ser};
            2'b01: usr_q <= {usr_sr_ser, usr_q[7:1]};
            2'b10: usr_q <= usr_data_in;
            default: usr_q <= usr_q;
        endcase
    end
    assign usr_data_out = usr_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word-level effect of a command on the register contents
    task automatic model(input logic [1:0] op, input int n, input logic [7:0] d, input logic s);
        if (op == 2'b10) ref_v = d;
        else if (op == 2'b00) ref_v = ((ref_v << n) | (s ? (1 << n) - 1 : 0)) & 255;
        else if (op == 2'b01) ref_v = (ref_v >> n) | (s ? (255 & ~(255 >> n)) : 0);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] n, input logic [7:0] d,
                           input logic s, input int hold, input string tag);
        int lat, act, bad, exp_lat, exp_act;
        logic [1:0] exp_sel;
        exp_sel = (op == 2'b10) ? 2'b10 : {1'b0, op[0]};
        exp_act = (op == 2'b10) ? 1 : (!op[1]) ? int'(n) : 0;
        exp_lat = (op == 2'b10) ? 3 : (!op[1] && n != 0) ? int'(n) + 2 : 2;
        @(negedge clock);
        check({tag, " ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_count = n; cmd_data = d; cmd_ser = s;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_count = 4'($urandom); cmd_data = 8'($urandom); cmd_ser = 1'($urandom);
        model(op, int'(n), d, s);
        lat = 0; act = 0; bad = 0;
        while (lat < 40) begin
            @(negedge clock);
            lat++;
            if (rsp_valid) break;
            rsp_ready = 1'($urandom);
            if (usr_select == exp_sel) act++;
            else if (usr_select != 2'b11) bad++;
            if (cmd_ready || !busy) bad++;
            if (usr_select == exp_sel && !exp_sel[1] && (usr_sl_ser != s || usr_sr_ser != s)) bad++;
            if (usr_select == 2'b10 && usr_data_in != d) bad++;
            if (usr_select == 2'b11 && (usr_data_in != 0 || usr_sl_ser || usr_sr_ser)) bad++;
        end
        rsp_ready = (hold == 0);
        last_rsp = rsp_data;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " active"}, act, exp_act);
        check({tag, " drive"}, bad, 0);
        check({tag, " data"}, rsp_data, ref_v);
        bad = 0;
        repeat (hold) begin
            @(negedge clock);
            if (!rsp_valid || rsp_data != ref_v || cmd_ready || usr_select != 2'b11) bad++;
        end
        if (hold > 0) check({tag, " hold"}, bad, 0);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        @(negedge clock);
        check({tag, " done"}, {rsp_valid, cmd_ready, busy}, 3'b010);
    endtask

    initial begin
        int seen;
        // Reset held for two cycles
        repeat (2) @(negedge clock);
        check("t1 rst", {cmd_ready, rsp_valid, busy, usr_select}, 5'b00011);
        check("t1 rst data", {rsp_data, usr_data_in, usr_sl_ser, usr_sr_ser}, 18'd0);
        clear = 1'b0;
        #1 check("t1 ready low", cmd_ready, 0);
        @(posedge clock);
        #1 check("t1 ready rise", cmd_ready, 1);
        ref_v = 0;

        run_cmd(2'b10, 4'd0, 8'hAB, 1'b0, 0, "t2");
        check("t2 value", last_rsp, 8'hAB);
        run_cmd(2'b01, 4'd3, 8'h00, 1'b1, 1, "t3");
        check("t3 value", last_rsp, 8'hF5);
        run_cmd(2'b10, 4'd0, 8'hAB, 1'b0, 0, "t4 load");
        run_cmd(2'b00, 4'd2, 8'h00, 1'b0, 0, "t4");
        check("t4 value", last_rsp, 8'hAC);
        run_cmd(2'b10, 4'd0, 8'hAB, 1'b0, 0, "t5 load");
        run_cmd(2'b11, 4'd7, 8'h55, 1'b1, 4, "t5 read");
        check("t5 read value", last_rsp, 8'hAB);
        run_cmd(2'b01, 4'd0, 8'h55, 1'b1, 4, "t5 zero");
        check("t5 zero value", last_rsp, 8'hAB);
        run_cmd(2'b00, 4'd15, 8'h00, 1'b1, 0, "full left");
        check("full left value", last_rsp, 8'hFF);
        run_cmd(2'b01, 4'd15, 8'h00, 1'b0, 2, "full right");
        check("full right value", last_rsp, 8'h00);

        // Clear pulsed after two shift cycles of a five-shift command
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 4'd5; cmd_ser = 1'b1;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        clear = 1'b1;
        #1;
        check("t6 clr ctl", {cmd_ready, rsp_valid, busy, usr_select}, 5'b00011);
        check("t6 clr data", {rsp_data, usr_data_in, usr_sl_ser, usr_sr_ser}, 18'd0);
        @(negedge clock);
        clear = 1'b0;
        ref_v = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clock);
            if (rsp_valid) seen++;
        end
        check("t6 no rsp", seen, 0);
        run_cmd(2'b10, 4'd0, 8'h3C, 1'b0, 0, "t6 load");
        check("t6 value", last_rsp, 8'h3C);

        // Randomized command stream with random back-pressure
        repeat (40) begin
            logic [1:0] op;
            logic [3:0] n;
            op = 2'($urandom_range(0, 3));
            n = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom);
            run_cmd(op, n, 8'($urandom), 1'($urandom), $urandom_range(0, 3), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
